wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 16, meaning slave cycles allowed without ack/err before the arbiter terminates the access with err (legal range 2..255).
REQ-002 The block SHALL have port clk_i, input, 1, single system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports m0_adr_i / m1_adr_i, input, `ADR_WIDTH, master byte address.
REQ-005 The block SHALL have ports m0_dat_i / m1_dat_i, input, `DAT_WIDTH, master write data.
REQ-006 The block SHALL have ports m0_we_i / m1_we_i and m0_stb_i / m1_stb_i, input, 1 each, write enable and strobe.
REQ-007 The block SHALL have ports m0_dat_o / m1_dat_o, output, `DAT_WIDTH, read data; both driven from s_dat_i.
REQ-008 The block SHALL have ports m0_ack_o / m1_ack_o and m0_err_o / m1_err_o, output, 1 each, cycle termination.
REQ-009 The block SHALL have slave ports s_adr_o (`ADR_WIDTH), s_dat_o (`DAT_WIDTH), s_we_o (1), s_stb_o (1) as outputs, and s_dat_i (`DAT_WIDTH), s_ack_i (1), s_err_i (1) as inputs, connecting to one Wishbone slave such as the RAM.
REQ-010 The block SHALL have port grant_o, output, 2, one-hot owner of the slave: 01 = m0, 10 = m1, 00 = none.

Function
REQ-011 The block SHALL implement states IDLE, BUSY and ABORT.
REQ-012 IDLE: s_stb_o = 0, grant_o = 00, and all master ack/err = 0.
REQ-013 IDLE: on a clock edge with any m*_stb_i high, the block SHALL latch a grant and enter BUSY, giving exactly one cycle of arbitration latency.
REQ-014 Grant rule: if only one strobe is high, that master wins.
REQ-015 Grant rule: if both strobes are high, the master not granted most recently wins (round-robin); after reset, m0 counts as most recent, so m1 wins the first tie.
REQ-016 BUSY: s_adr_o, s_dat_o, s_we_o and s_stb_o SHALL combinationally follow the granted master's signals.
REQ-017 BUSY: granted m*_ack_o = s_ack_i & its stb; granted m*_err_o = s_err_i & its stb; the non-granted master's ack/err SHALL be 0.
REQ-018 Outside BUSY, s_adr_o, s_dat_o and s_we_o SHALL be driven from m0 and s_stb_o SHALL be 0.
REQ-019 The grant SHALL NOT change while in BUSY or ABORT, regardless of the other master's strobe.
REQ-020 BUSY -> IDLE on the edge where the granted master's stb is low; "most recently granted" SHALL update at that edge.
REQ-021 Timeout counter (8 bits): cleared on entry to BUSY; increments each BUSY cycle with s_ack_i = s_err_i = 0; holds once ack or err is seen for the current access.
REQ-022 When the counter reaches TIMEOUT-1 with no ack/err, the block SHALL enter ABORT on the next edge.
REQ-023 ABORT: s_stb_o = 0; granted m*_err_o = its stb; m*_ack_o = 0; grant_o unchanged.
REQ-024 ABORT -> IDLE when the granted stb is low, updating round-robin as in REQ-020.
REQ-025 Granted master dropping stb in the same cycle the slave acks: the ack reaches the master only while its stb is high; the transition to IDLE still occurs.
REQ-026 Back-to-back accesses: after returning to IDLE, a pending request from the other master SHALL win at the next edge, guaranteeing no starvation.
REQ-027 m*_dat_o SHALL equal s_dat_i at all times; validity is qualified only by ack.

Reset
REQ-028 While rst_i = 0, the block SHALL immediately (asynchronously) enter state IDLE, clear the counter, set grant_o = 00, and set round-robin last = m0.
REQ-029 While rst_i = 0, s_stb_o and all master ack/err outputs SHALL be 0, including when reset is asserted mid-access.
REQ-030 The first arbitration SHALL occur on the first rising edge after rst_i deasserts.

Verification
REQ-031 m0 single read, adr 0x10, slave acks 1 cycle after s_stb_o -> grant_o = 01 one cycle after m0_stb_i; m0_ack_o = 1 with s_dat_i; IDLE one edge after m0_stb_i drops.
REQ-032 Both strobes rise together after reset -> m1 granted first (grant_o = 10); after m1 drops stb, m0 granted on the next edge; m1 re-requesting immediately still waits for m0 to finish.
REQ-033 m0 write to adr 0x2000 with slave returning err -> m0_err_o = 1, m0_ack_o = 0; m1 outputs stay 0 throughout.
REQ-034 TIMEOUT = 4, slave never responds -> s_stb_o drops after 4 BUSY cycles; m0_err_o = 1 until m0_stb_i falls; then IDLE with grant_o = 00.
REQ-035 rst_i pulled low mid-BUSY, between edges -> s_stb_o, grant_o and all ack/err go to 0 without waiting for a clock edge; after release, a tie is granted to m1.

Source files
------------

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : wb_arbiter
// Brief   : Two-master round-robin Wishbone arbiter with slave timeout/abort.
// Revision: 1.0 - initial release
// ============================================================================

`ifndef ADR_WIDTH
`define ADR_WIDTH 32
`endif
`ifndef DAT_WIDTH
`define DAT_WIDTH 32
`endif

module wb_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [`ADR_WIDTH-1:0] m0_adr_i,
  input  logic [`DAT_WIDTH-1:0] m0_dat_i,
  input  logic                  m0_we_i,
  input  logic                  m0_stb_i,
  output logic [`DAT_WIDTH-1:0] m0_dat_o,
  output logic                  m0_ack_o,
  output logic                  m0_err_o,
  input  logic [`ADR_WIDTH-1:0] m1_adr_i,
  input  logic [`DAT_WIDTH-1:0] m1_dat_i,
  input  logic                  m1_we_i,
  input  logic                  m1_stb_i,
  output logic [`DAT_WIDTH-1:0] m1_dat_o,
  output logic                  m1_ack_o,
  output logic                  m1_err_o,
  output logic [`ADR_WIDTH-1:0] s_adr_o,
  output logic [`DAT_WIDTH-1:0] s_dat_o,
  output logic                  s_we_o,
  output logic                  s_stb_o,
  input  logic [`DAT_WIDTH-1:0] s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  output logic [1:0]            grant_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  localparam logic [7:0] c_cnt_last = 8'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q,  last_d;   // 1: m1 was granted most recently
  logic [7:0] cnt_q,   cnt_d;
  logic       seen_q,  seen_d;   // ack/err already observed for this access

  logic w_sel_m1;
  logic w_sel_stb;
  logic w_busy;
  logic w_abort;

  assign w_sel_m1  = grant_q[1];
  assign w_sel_stb = w_sel_m1 ? m1_stb_i : m0_stb_i;
  assign w_busy    = (state_q == ST_BUSY);
  assign w_abort   = (state_q == ST_ABORT);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    case (state_q)
      ST_IDLE: begin
        if (m0_stb_i || m1_stb_i) begin
          state_d = ST_BUSY;
          cnt_d   = 8'd0;
          seen_d  = 1'b0;
          if (m0_stb_i && m1_stb_i) begin
            grant_d = last_q ? 2'b01 : 2'b10;
          end else begin
            grant_d = m1_stb_i ? 2'b10 : 2'b01;
          end
        end
      end
      ST_BUSY: begin
        if (!w_sel_stb) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
          last_d  = w_sel_m1;
        end else if (s_ack_i || s_err_i) begin
          seen_d = 1'b1;
        end else if (!seen_q) begin
          if (cnt_q == c_cnt_last) begin
            state_d = ST_ABORT;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_ABORT: begin
        if (!w_sel_stb) begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
          last_d  = w_sel_m1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      last_q  <= 1'b0;
      cnt_q   <= 8'd0;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
    end
  end

  // Reset forces IDLE asynchronously, so every state-qualified output drops with it.
  assign s_adr_o  = (w_busy && w_sel_m1) ? m1_adr_i : m0_adr_i;
  assign s_dat_o  = (w_busy && w_sel_m1) ? m1_dat_i : m0_dat_i;
  assign s_we_o   = (w_busy && w_sel_m1) ? m1_we_i  : m0_we_i;
  assign s_stb_o  = w_busy && w_sel_stb;

  assign m0_ack_o = w_busy && grant_q[0] && m0_stb_i && s_ack_i;
  assign m1_ack_o = w_busy && grant_q[1] && m1_stb_i && s_ack_i;
  assign m0_err_o = grant_q[0] && m0_stb_i && ((w_busy && s_err_i) || w_abort);
  assign m1_err_o = grant_q[1] && m1_stb_i && ((w_busy && s_err_i) || w_abort);

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign grant_o  = grant_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_wb_arbiter
// Brief   : Directed self-checking bench for wb_arbiter (TIMEOUT = 4).
// Revision: 1.0 - initial release
// ============================================================================

`ifndef ADR_WIDTH
`define ADR_WIDTH 32
`endif
`ifndef DAT_WIDTH
`define DAT_WIDTH 32
`endif

module tb_wb_arbiter;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic [`ADR_WIDTH-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [`DAT_WIDTH-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic                  m0_we_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic                  m1_we_i, m1_stb_i, m1_ack_o, m1_err_o;
  logic                  s_we_o, s_stb_o, s_ack_i, s_err_i;
  logic [1:0]            grant_o;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  wb_arbiter #(.TIMEOUT(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_stb_i(m0_stb_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_stb_i(m1_stb_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    m0_stb_i = 1'b1; m1_stb_i = 1'b1; s_ack_i = 1'b1; s_err_i = 1'b1;
    @(posedge clk_i); #1;
    n_cmp++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL rst_grant: got %b expected 00", grant_o); end
    n_cmp++; if (s_stb_o !== 1'b0) begin n_fail++; $display("FAIL rst_stb: got %b expected 0", s_stb_o); end
    n_cmp++; if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 4'b0000) begin n_fail++;
      $display("FAIL rst_ackerr: got %b expected 0000", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
    @(negedge clk_i);
    m0_stb_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0; s_err_i = 1'b0;
    rst_i = 1'b1;
  endtask

  task automatic test_tie();
    @(negedge clk_i);
    m0_adr_i = 32'h100; m0_we_i = 1'b0; m0_stb_i = 1'b1;
    m1_adr_i = 32'h200; m1_dat_i = 32'hA5A5_0001; m1_we_i = 1'b1; m1_stb_i = 1'b1;
    #1;
    n_cmp++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL tie_latency: got %b expected 00", grant_o); end
    @(negedge clk_i); #1;
    n_cmp++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL tie_first_m1: got %b expected 10", grant_o); end
    n_cmp++; if ({s_adr_o, s_dat_o, s_we_o, s_stb_o} !== {32'h200, 32'hA5A5_0001, 1'b1, 1'b1}) begin n_fail++;
      $display("FAIL tie_mux_m1: got adr %h dat %h we %b stb %b expected 200 a5a50001 1 1", s_adr_o, s_dat_o, s_we_o, s_stb_o); end
    s_ack_i = 1'b1; s_dat_i = 32'h1111_2222; #1;
    n_cmp++; if ({m1_ack_o, m0_ack_o} !== 2'b10) begin n_fail++; $display("FAIL tie_ack_m1: got m1/m0 %b expected 10", {m1_ack_o, m0_ack_o}); end
    n_cmp++; if (m0_dat_o !== 32'h1111_2222) begin n_fail++; $display("FAIL dat_passthru: got %h expected 11112222", m0_dat_o); end
    @(negedge clk_i);
    m1_stb_i = 1'b0; s_ack_i = 1'b0; #1;
    n_cmp++; if (s_stb_o !== 1'b0) begin n_fail++; $display("FAIL tie_stb_follow: got %b expected 0", s_stb_o); end
    @(negedge clk_i);
    m1_stb_i = 1'b1; m1_adr_i = 32'h204; #1;
    n_cmp++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL tie_idle1: got %b expected 00", grant_o); end
    @(negedge clk_i); #1;
    n_cmp++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL tie_rr_m0: got %b expected 01", grant_o); end
    n_cmp++; if (s_adr_o !== 32'h100) begin n_fail++; $display("FAIL tie_mux_m0: got %h expected 100", s_adr_o); end
    @(negedge clk_i); #1;
    n_cmp++; if (grant_o !== 2'b01) begin n_fail++; $display("FAIL tie_hold: got %b expected 01", grant_o); end
    s_ack_i = 1'b1; #1;
    n_cmp++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin n_fail++; $display("FAIL tie_ack_m0: got m0/m1 %b expected 10", {m0_ack_o, m1_ack_o}); end
    @(negedge clk_i);
    m0_stb_i = 1'b0; s_ack_i = 1'b0;
    @(negedge clk_i); #1;
    n_cmp++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL tie_idle2: got %b expected 00", grant_o); end
    @(negedge clk_i); #1;
    n_cmp++; if (grant_o !== 2'b10 || s_adr_o !== 32'h204) begin n_fail++;
      $display("FAIL b2b_m1: got grant %b adr %h expected 10 204", grant_o, s_adr_o); end
    @(negedge clk_i);
    m1_stb_i = 1'b0; m1_we_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_single_read();
    @(negedge clk_i);
    m0_adr_i = 32'h10; m0_we_i = 1'b0; m0_stb_i = 1'b1; #1;
    n_cmp++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL rd_latency: got %b expected 00", grant_o); end
    @(negedge clk_i); #1;
    n_cmp++; if ({grant_o, s_stb_o, m0_ack_o} !== 4'b0110) begin n_fail++;
      $display("FAIL rd_grant: got grant %b stb %b ack %b expected 01 1 0", grant_o, s_stb_o, m0_ack_o); end
    n_cmp++; if (s_adr_o !== 32'h10) begin n_fail++; $display("FAIL rd_adr: got %h expected 10", s_adr_o); end
    @(negedge clk_i);
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF; #1;
    n_cmp++; if ({m0_ack_o, m1_ack_o} !== 2'b10) begin n_fail++; $display("FAIL rd_ack: got m0/m1 %b expected 10", {m0_ack_o, m1_ack_o}); end
    n_cmp++; if (m0_dat_o !== 32'hDEAD_BEEF || m1_dat_o !== 32'hDEAD_BEEF) begin n_fail++;
      $display("FAIL rd_data: got %h/%h expected deadbeef", m0_dat_o, m1_dat_o); end
    @(negedge clk_i);
    m0_stb_i = 1'b0; #1;
    n_cmp++; if ({m0_ack_o, s_stb_o} !== 2'b00) begin n_fail++; $display("FAIL drop_ack_gated: got ack/stb %b expected 00", {m0_ack_o, s_stb_o}); end
    @(negedge clk_i);
    s_ack_i = 1'b0; #1;
    n_cmp++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL rd_idle: got %b expected 00", grant_o); end
  endtask

  task automatic test_write_err();
    @(negedge clk_i);
    m0_adr_i = 32'h2000; m0_dat_i = 32'h1234_5678; m0_we_i = 1'b1; m0_stb_i = 1'b1;
    @(negedge clk_i); #1;
    n_cmp++; if ({grant_o, s_adr_o, s_dat_o, s_we_o} !== {2'b01, 32'h2000, 32'h1234_5678, 1'b1}) begin n_fail++;
      $display("FAIL wr_mux: got grant %b adr %h dat %h we %b expected 01 2000 12345678 1", grant_o, s_adr_o, s_dat_o, s_we_o); end
    s_err_i = 1'b1; #1;
    n_cmp++; if ({m0_err_o, m0_ack_o, m1_ack_o, m1_err_o} !== 4'b1000) begin n_fail++;
      $display("FAIL wr_err: got m0err/m0ack/m1ack/m1err %b expected 1000", {m0_err_o, m0_ack_o, m1_ack_o, m1_err_o}); end
    @(negedge clk_i);
    m0_stb_i = 1'b0; #1;
    n_cmp++; if ({m0_err_o, m1_err_o} !== 2'b00) begin n_fail++; $display("FAIL wr_err_gated: got %b expected 00", {m0_err_o, m1_err_o}); end
    @(negedge clk_i);
    s_err_i = 1'b0; m0_we_i = 1'b0; #1;
    n_cmp++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL wr_idle: got %b expected 00", grant_o); end
  endtask

  task automatic test_ack_hold();
    @(negedge clk_i);
    m0_adr_i = 32'h40; m0_stb_i = 1'b1;
    @(negedge clk_i);
    s_ack_i = 1'b1; #1;
    n_cmp++; if (m0_ack_o !== 1'b1) begin n_fail++; $display("FAIL hold_ack: got %b expected 1", m0_ack_o); end
    @(negedge clk_i);
    s_ack_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i); #1;
      n_cmp++; if ({s_stb_o, m0_err_o} !== 2'b10) begin n_fail++;
        $display("FAIL hold_no_abort[%0d]: got stb/err %b expected 10", i, {s_stb_o, m0_err_o}); end
    end
    @(negedge clk_i);
    m0_stb_i = 1'b0;
    @(negedge clk_i);
  endtask

  task automatic test_timeout();
    @(negedge clk_i);
    m0_adr_i = 32'h80; m0_stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); #1;
      n_cmp++; if (s_stb_o !== 1'b1) begin n_fail++; $display("FAIL to_busy[%0d]: got %b expected 1", i, s_stb_o); end
    end
    @(negedge clk_i); #1;
    n_cmp++; if ({s_stb_o, m0_err_o, m0_ack_o, m1_err_o, grant_o} !== 6'b010001) begin n_fail++;
      $display("FAIL to_abort: got stb/err/ack/m1err/grant %b expected 010001", {s_stb_o, m0_err_o, m0_ack_o, m1_err_o, grant_o}); end
    @(negedge clk_i); #1;
    n_cmp++; if (m0_err_o !== 1'b1) begin n_fail++; $display("FAIL to_err_hold: got %b expected 1", m0_err_o); end
    m0_stb_i = 1'b0; #1;
    n_cmp++; if (m0_err_o !== 1'b0) begin n_fail++; $display("FAIL to_err_drop: got %b expected 0", m0_err_o); end
    @(negedge clk_i); #1;
    n_cmp++; if (grant_o !== 2'b00) begin n_fail++; $display("FAIL to_idle: got %b expected 00", grant_o); end
  endtask

  task automatic test_reset_mid();
    // m1 completes first, so only a reset can bring "last" back to m0
    @(negedge clk_i);
    m1_adr_i = 32'h300; m1_stb_i = 1'b1;
    @(negedge clk_i);
    s_ack_i = 1'b1;
    @(negedge clk_i);
    m1_stb_i = 1'b0; s_ack_i = 1'b0;
    @(negedge clk_i);
    m0_adr_i = 32'h500; m0_stb_i = 1'b1;
    @(negedge clk_i);
    s_ack_i = 1'b1; #1;
    n_cmp++; if ({grant_o, s_stb_o, m0_ack_o} !== 4'b0111) begin n_fail++;
      $display("FAIL mid_pre: got grant %b stb %b ack %b expected 01 1 1", grant_o, s_stb_o, m0_ack_o); end
    #2 rst_i = 1'b0;
    #1;
    n_cmp++; if ({grant_o, s_stb_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 7'b0000000) begin n_fail++;
      $display("FAIL mid_async: got grant %b stb %b ackerr %b expected 00 0 0000",
               grant_o, s_stb_o, {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}); end
    @(negedge clk_i);
    s_ack_i = 1'b0; m1_stb_i = 1'b1; rst_i = 1'b1;
    @(negedge clk_i); #1;
    n_cmp++; if (grant_o !== 2'b10) begin n_fail++; $display("FAIL mid_tie_m1: got %b expected 10", grant_o); end
    @(negedge clk_i);
    m0_stb_i = 1'b0; m1_stb_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    rst_i = 1'b0;
    m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_stb_i = 1'b0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
    test_reset();
    test_tie();
    test_single_read();
    test_write_err();
    test_ack_hold();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
